// File: rtl/instruction_fetcher.sv
// Fetch front end: owns the PC, issues one cache fetch at a time, follows JAL
// statically and buffers {inst, pc, predicted pc} in a small FIFO for decode.
module instruction_fetcher #(
    parameter int          QUEUE_BITS = 2,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        i_waiting,
    output logic [31:0] i_addr,
    input  logic [31:0] i_result,
    input  logic        i_m_ready,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_pred_pc,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic [1:0]  dbg_state
);

    localparam int DEPTH = 1 << QUEUE_BITS;
    localparam logic [QUEUE_BITS:0] FULL = {1'b1, {QUEUE_BITS{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    // Handshakes: the cache response is taken only while i_waiting is high and
    // i_m_ready is set; a decoder pop happens when dec_valid && dec_ready.
    // Everything is frozen while rdy_in is low; flush overrides push and pop.
    state_t                  state_q, state_d;
    logic [31:0]             pc_q, pc_d;
    logic                    waiting_q, waiting_d;
    logic [31:0]             addr_q, addr_d;
    logic [QUEUE_BITS-1:0]   head_q, head_d;
    logic [QUEUE_BITS-1:0]   tail_q, tail_d;
    logic [QUEUE_BITS:0]     count_q, count_d;
    logic [31:0]             fifo_inst_q [DEPTH];
    logic [31:0]             fifo_pc_q   [DEPTH];
    logic [31:0]             fifo_pred_q [DEPTH];

    logic        push;
    logic        pop;
    logic [31:0] jal_imm;
    logic [31:0] pred_pc;

    assign jal_imm = {{11{i_result[31]}}, i_result[31], i_result[19:12],
                      i_result[20], i_result[30:21], 1'b0};
    assign pred_pc = (i_result[6:0] == 7'b1101111) ? (addr_q + jal_imm)
                                                   : (addr_q + 32'd4);

    assign push = (state_q == ST_WAIT) && i_m_ready && !flush;
    assign pop  = (count_q != '0) && dec_ready && !flush;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        waiting_d = waiting_q;
        addr_d    = addr_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (flush) begin
            pc_d    = flush_pc;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            // An in-flight cache access cannot be cancelled; its word is dropped.
            if (state_q != ST_IDLE) begin
                if (i_m_ready) begin
                    waiting_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    state_d   = ST_DISCARD;
                end
            end
        end else begin
            if (pop)  head_d = head_q + 1'b1;
            if (push) tail_d = tail_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            case (state_q)
                ST_IDLE: begin
                    if (count_q < FULL) begin
                        waiting_d = 1'b1;
                        addr_d    = pc_q;
                        state_d   = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (i_m_ready) begin
                        pc_d      = pred_pc;
                        waiting_d = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end
                ST_DISCARD: begin
                    if (i_m_ready) begin
                        waiting_d = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            waiting_q <= 1'b0;
            addr_q    <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_inst_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
                fifo_pred_q[i] <= '0;
            end
        end else if (rdy_in) begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            waiting_q <= waiting_d;
            addr_q    <= addr_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            if (push) begin
                fifo_inst_q[tail_q] <= i_result;
                fifo_pc_q[tail_q]   <= addr_q;
                fifo_pred_q[tail_q] <= pred_pc;
            end
        end
    end

    assign i_waiting   = waiting_q;
    assign i_addr      = addr_q;
    assign dec_valid   = (count_q != '0);
    assign dec_inst    = fifo_inst_q[head_q];
    assign dec_pc      = fifo_pc_q[head_q];
    assign dec_pred_pc = fifo_pred_q[head_q];
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Bench for instruction_fetcher: transaction-level model of the fetch stream
// and decode queue, directed scenarios followed by randomized traffic.
module tb_instruction_fetcher;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        i_waiting;
  logic [31:0] i_addr;
  logic [31:0] i_result = '0;
  logic        i_m_ready = 1'b0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic [31:0] dec_pred_pc;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic [1:0]  dbg_state;

  instruction_fetcher #(.QUEUE_BITS(2), .RESET_PC(32'h0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .i_waiting(i_waiting), .i_addr(i_addr), .i_result(i_result),
    .i_m_ready(i_m_ready), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_inst(dec_inst), .dec_pc(dec_pc), .dec_pred_pc(dec_pred_pc),
    .flush(flush), .flush_pc(flush_pc), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  int vectors = 0;
  int miscompares = 0;

  // reference model: expected decode queue plus the fetch in flight
  logic [31:0] exp_inst_q[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_pred_q[$];
  bit          m_out;
  bit          m_drop;
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] issue_log[$];
  int          issues;
  bit          prev_wait;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return NOP;
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] w, input logic [31:0] pc);
    int off;
    if (w[6:0] != 7'b1101111) return pc + 32'd4;
    off = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096;
    if (w[31]) off = off - (1 << 20);
    return pc + 32'(off);
  endfunction

  function automatic logic [31:0] encode_jal(input int off);
    logic [31:0] o;
    o = 32'(off);
    return {o[20], o[10:1], o[11], o[19:12], 5'd0, 7'b1101111};
  endfunction

  task automatic model_reset();
    exp_inst_q.delete();
    exp_pc_q.delete();
    exp_pred_q.delete();
    m_out = 0;
    m_drop = 0;
    m_pc = 32'h0;
    m_addr = 32'h0;
    prev_wait = 0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    i_m_ready = 1'b0; dec_ready = 1'b0; flush = 1'b0; rdy_in = 1'b1;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    model_reset();
  endtask

  // driver + scoreboard: called just after a falling edge
  task automatic cycle(input bit mr, input bit dr, input bit fl,
                       input logic [31:0] fpc, input bit rdy);
    int sz;
    logic [31:0] w;
    logic [31:0] pr;
    vectors++;
    if (i_waiting !== m_out) begin
      miscompares++;
      $display("FAIL sb_waiting: got %0b want %0b at %0t", i_waiting, m_out, $time);
    end
    if (m_out) begin
      vectors++;
      if (i_addr !== m_addr) begin
        miscompares++;
        $display("FAIL sb_addr: got %h want %h at %0t", i_addr, m_addr, $time);
      end
    end
    vectors++;
    if (dec_valid !== (exp_pc_q.size() != 0)) begin
      miscompares++;
      $display("FAIL sb_valid: got %0b want %0b at %0t", dec_valid, exp_pc_q.size() != 0, $time);
    end
    if (exp_pc_q.size() != 0) begin
      vectors++;
      if (dec_inst !== exp_inst_q[0] || dec_pc !== exp_pc_q[0] || dec_pred_pc !== exp_pred_q[0]) begin
        miscompares++;
        $display("FAIL sb_entry: got %h/%h/%h want %h/%h/%h at %0t", dec_inst, dec_pc,
                 dec_pred_pc, exp_inst_q[0], exp_pc_q[0], exp_pred_q[0], $time);
      end
    end
    if (i_waiting && !prev_wait) begin
      issues++;
      issue_log.push_back(i_addr);
    end
    prev_wait = i_waiting;

    i_m_ready = mr;
    i_result  = word_at(i_addr);
    dec_ready = dr;
    flush     = fl;
    flush_pc  = fpc;
    rdy_in    = rdy;
    @(posedge clk_in);
    if (rdy) begin
      sz = exp_pc_q.size();
      if (fl) begin
        exp_inst_q.delete(); exp_pc_q.delete(); exp_pred_q.delete();
        m_pc = fpc;
        if (m_out && mr) begin
          m_out = 0;
          m_drop = 0;
        end else if (m_out) begin
          m_drop = 1;
        end
      end else begin
        if (dr && sz > 0) begin
          void'(exp_inst_q.pop_front());
          void'(exp_pc_q.pop_front());
          void'(exp_pred_q.pop_front());
        end
        if (m_out) begin
          if (mr) begin
            if (!m_drop) begin
              w  = word_at(m_addr);
              pr = model_next(w, m_addr);
              exp_inst_q.push_back(w);
              exp_pc_q.push_back(m_addr);
              exp_pred_q.push_back(pr);
              m_pc = pr;
            end
            m_out = 0;
            m_drop = 0;
          end
        end else if (sz < 4) begin
          m_out = 1;
          m_addr = m_pc;
        end
      end
    end
    @(negedge clk_in);
  endtask

  task automatic redirect(input logic [31:0] pc);
    cycle(1, 0, 1, pc, 1);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (i_waiting !== 1'b0 || i_addr !== 32'h0 || dec_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: got w=%0b a=%h v=%0b want 0/0/0", i_waiting, i_addr, dec_valid);
    end
    vectors++;
    if (dec_inst !== 32'h0 || dec_pc !== 32'h0 || dec_pred_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_head: got %h/%h/%h want 0/0/0", dec_inst, dec_pc, dec_pred_pc);
    end
  endtask

  task automatic test_hits();
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (i_waiting !== ((k % 2) == 1)) begin
        miscompares++;
        $display("FAIL hits_bubble: cycle %0d got %0b want %0b", k, i_waiting, (k % 2) == 1);
      end
      if (k % 2 == 1) begin
        vectors++;
        if (i_addr !== 32'(4 * (k / 2))) begin
          miscompares++;
          $display("FAIL hits_addr: got %h want %h", i_addr, 4 * (k / 2));
        end
      end
      cycle(1, 0, 0, 0, 1);
    end
    for (int j = 0; j < 4; j++) begin
      vectors++;
      if (dec_valid !== 1'b1 || dec_pc !== 32'(4 * j) || dec_pred_pc !== 32'(4 * j + 4) || dec_inst !== NOP) begin
        miscompares++;
        $display("FAIL hits_entry: got %0b %h/%h/%h want 1 %h/%h/%h", dec_valid, dec_inst,
                 dec_pc, dec_pred_pc, NOP, 4 * j, 4 * j + 4);
      end
      cycle(0, 1, 0, 0, 1);
    end
  endtask

  task automatic test_jal();
    logic [31:0] want [11];
    want = '{32'h20, 32'h24, 32'h28, 32'h2C, 32'h30, 32'h34, 32'h38, 32'h3C, 32'h40, 32'h30, 32'h34};
    mem[32'h10] = 32'h0100_006F;
    mem[32'h40] = 32'hFF1F_F06F;
    issue_log.delete();
    cycle(1, 1, 0, 0, 1);
    vectors++;
    if (dec_valid !== 1'b1 || dec_pc !== 32'h10 || dec_pred_pc !== 32'h20) begin
      miscompares++;
      $display("FAIL jal_entry: got %0b %h/%h want 1 00000010/00000020", dec_valid, dec_pc, dec_pred_pc);
    end
    repeat (30) cycle(1, 1, 0, 0, 1);
    for (int i = 0; i < 11; i++) begin
      vectors++;
      if (i >= issue_log.size() || issue_log[i] !== want[i]) begin
        miscompares++;
        $display("FAIL jal_issue%0d: got %h want %h", i,
                 (i < issue_log.size()) ? issue_log[i] : 32'hx, want[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    redirect(32'h200);
    issues = 0;
    repeat (12) cycle(1, 0, 0, 0, 1);
    vectors++;
    if (issues !== 4 || i_waiting !== 1'b0 || dec_valid !== 1'b1 || dec_pc !== 32'h200) begin
      miscompares++;
      $display("FAIL bp_fill: got issues=%0d w=%0b v=%0b pc=%h want 4/0/1/00000200",
               issues, i_waiting, dec_valid, dec_pc);
    end
    issues = 0;
    cycle(1, 1, 0, 0, 1);
    repeat (6) cycle(1, 0, 0, 0, 1);
    vectors++;
    if (issues !== 1 || i_waiting !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_refill: got issues=%0d w=%0b want 1/0", issues, i_waiting);
    end
  endtask

  task automatic test_flush_miss();
    redirect(32'h300);
    repeat (4) cycle(1, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    vectors++;
    if (i_waiting !== 1'b1 || i_addr !== 32'h308) begin
      miscompares++;
      $display("FAIL fm_issue: got w=%0b a=%h want 1/00000308", i_waiting, i_addr);
    end
    cycle(0, 0, 1, 32'h100, 1);
    for (int k = 0; k < 10; k++) begin
      vectors++;
      if (i_waiting !== 1'b1 || dec_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL fm_hold: cycle %0d got w=%0b v=%0b want 1/0", k, i_waiting, dec_valid);
      end
      if (k < 9) cycle(0, 0, 0, 0, 1);
    end
    cycle(1, 0, 0, 0, 1);
    vectors++;
    if (dec_valid !== 1'b0 || i_waiting !== 1'b0) begin
      miscompares++;
      $display("FAIL fm_drop: got v=%0b w=%0b want 0/0", dec_valid, i_waiting);
    end
    cycle(0, 0, 0, 0, 1);
    vectors++;
    if (i_waiting !== 1'b1 || i_addr !== 32'h100) begin
      miscompares++;
      $display("FAIL fm_target: got w=%0b a=%h want 1/00000100", i_waiting, i_addr);
    end
  endtask

  task automatic test_flush_coincident();
    redirect(32'h400);
    repeat (4) cycle(1, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(1, 1, 1, 32'h500, 1);
    vectors++;
    if (dec_valid !== 1'b0 || i_waiting !== 1'b0) begin
      miscompares++;
      $display("FAIL fc_clear: got v=%0b w=%0b want 0/0", dec_valid, i_waiting);
    end
    cycle(0, 0, 0, 0, 1);
    vectors++;
    if (i_waiting !== 1'b1 || i_addr !== 32'h500) begin
      miscompares++;
      $display("FAIL fc_target: got w=%0b a=%h want 1/00000500", i_waiting, i_addr);
    end
  endtask

  task automatic test_rdy_stall();
    redirect(32'h600);
    cycle(0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      cycle((k % 2) == 0, 1, 0, 0, 0);
      vectors++;
      if (i_waiting !== 1'b1 || i_addr !== 32'h600 || dec_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rdy_freeze: cycle %0d got w=%0b a=%h v=%0b want 1/00000600/0",
                 k, i_waiting, i_addr, dec_valid);
      end
    end
    cycle(1, 0, 0, 0, 1);
    vectors++;
    if (dec_valid !== 1'b1 || dec_pc !== 32'h600 || i_waiting !== 1'b0) begin
      miscompares++;
      $display("FAIL rdy_capture: got v=%0b pc=%h w=%0b want 1/00000600/0", dec_valid, dec_pc, i_waiting);
    end
    cycle(0, 0, 0, 0, 1);
    rst_in = 1'b1;
    #1;
    vectors++;
    if (i_waiting !== 1'b0 || i_addr !== 32'h0 || dec_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL async_rst: got w=%0b a=%h v=%0b want 0/0/0", i_waiting, i_addr, dec_valid);
    end
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 16; i++) begin
      a = 32'($urandom_range(0, 255)) * 32'd4;
      mem[a] = encode_jal((int'($urandom_range(0, 64)) - 32) * 4);
    end
    for (int c = 0; c < 600; c++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0,
            32'($urandom_range(0, 255)) * 32'd4, $urandom_range(0, 9) != 0);
    end
  endtask

  initial begin
    test_reset();
    test_hits();
    test_jal();
    test_backpressure();
    test_flush_miss();
    test_flush_coincident();
    test_rdy_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_fetcher.md
Name: instruction_fetcher

Overview:
Front-end stage that sits directly upstream of the instruction/memory cache block. It owns the PC and issues one word fetch at a time over the cache's i_waiting/i_addr request interface. Returned words are predecoded so that JAL is followed statically; conditional branches are predicted not-taken. Each word is buffered with its PC and predicted next PC in a small FIFO that feeds the decoder over a valid/ready handshake. A flush from the commit side redirects the PC and empties the FIFO.

Parameters:
QUEUE_BITS, 2, log2 of FIFO depth (DEPTH = 2^QUEUE_BITS = 4)
RESET_PC, 32'h0, PC loaded at reset

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset; asynchronous, active-high
rdy_in  input  1  global enable; all state frozen while low
i_waiting  output  1  fetch request to cache; held high while a fetch is outstanding
i_addr  output  32  fetch address; stable while i_waiting high
i_result  input  32  instruction word from cache
i_m_ready  input  1  cache response valid; sampled only when i_waiting high
dec_valid  output  1  FIFO head valid
dec_ready  input  1  decoder accepts head
dec_inst  output  32  head instruction word
dec_pc  output  32  head PC
dec_pred_pc  output  32  predicted next PC for head
flush  input  1  redirect request (mispredict/exception)
flush_pc  input  32  redirect target

Behaviour:
- Reset (async, rst_in=1): pc=RESET_PC, state=IDLE, FIFO empty (head=tail=count=0), i_waiting=0, i_addr=0, dec_valid=0, dec_inst/dec_pc/dec_pred_pc=0.
- rdy_in=0: no register changes; outputs hold.
- All transitions below occur at posedge clk_in with rdy_in=1.
- State IDLE:
  - If !flush and count<DEPTH: i_waiting<=1, i_addr<=pc, go WAIT.
  - Otherwise stay IDLE.
- State WAIT:
  - If i_m_ready=1 and !flush: push {i_result, i_addr, pred}. pred = i_addr + J-imm (sign-extended, bit0=0) if i_result[6:0]==7'b1101111, else i_addr+4.
  - On that push: pc<=pred, i_waiting<=0, go IDLE.
- State DISCARD:
  - Entered when flush arrives while in WAIT with i_m_ready=0.
  - i_waiting stays high; the cache fetch cannot be aborted.
  - When i_m_ready=1, the word is dropped, i_waiting<=0, go IDLE.
- Minimum spacing: one bubble cycle with i_waiting low between requests, so at most one fetch is ever outstanding. Hit throughput is one word per 2 cycles.
- Latency on a hit (i_m_ready high the cycle after issue): issue edge E0, capture edge E1, dec_valid high after E1.
- Flush has priority over every other event in the same cycle:
  - pc<=flush_pc; FIFO emptied (count=0, dec_valid=0); any simultaneous pop or push is ignored.
  - IDLE -> IDLE, no issue this cycle.
  - WAIT with i_m_ready=1 -> word dropped, i_waiting<=0, IDLE.
  - WAIT with i_m_ready=0 -> DISCARD.
  - DISCARD -> DISCARD, pc updated again (last flush wins).
- FIFO:
  - Pop occurs when dec_valid && dec_ready; head advances modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH; count is QUEUE_BITS+1 bits wide.
  - The issue gate (count<DEPTH at issue) guarantees a push never overflows, because only the fetcher pushes and count cannot grow while WAIT.
  - A pop while empty is ignored.
- dec_inst/dec_pc/dec_pred_pc are read combinationally from the FIFO head entry and are valid whenever dec_valid=1.
- Arithmetic: all PC math is 32-bit, wrapping mod 2^32; no alignment checks.

Test Plan:
- Reset then hits: RESET_PC=0, cache returns i_m_ready=1 one cycle after each issue with words 0x00000013 -> i_addr sequence 0,4,8,12. Entries carry dec_pc 0,4,8,12 and dec_pred_pc 4,8,12,16. i_waiting shows one low cycle between requests.
- JAL follow: word at pc=0x10 is 0x0100006F (jal x0,+16) -> entry has dec_pred_pc=0x20 and the next i_addr=0x20. A negative immediate (0xFF1FF06F, -16) at 0x40 gives next i_addr=0x30.
- Backpressure: dec_ready=0 -> exactly 4 entries fill and i_waiting stays low while count=4. Raising dec_ready for 1 cycle triggers exactly one new fetch.
- Flush during slow miss: flush=1, flush_pc=0x100 while WAIT and i_m_ready low for 10 cycles -> FIFO empty and i_waiting held. The returned word is not enqueued; the next request has i_addr=0x100.
- Flush coincident with response, push and pop: flush and i_m_ready both 1 with dec_ready=1 and count=2 -> count=0 and nothing pushed; the next i_addr=flush_pc.
- rdy_in low mid-WAIT for 3 cycles with i_m_ready pulsing -> no capture and no state change. The response is captured only once rdy_in returns. An async rst_in pulse mid-WAIT clears i_waiting immediately, without waiting for a clock edge.
